// File: rtl/bram_fifo_pkg.sv
// Shared types and pointer helpers for the block-RAM FWFT FIFO.
package bram_fifo_pkg;

    typedef enum logic {
        EMPTY_OUT = 1'b0,
        HOLD      = 1'b1
    } out_state_t;

    // Pointer arithmetic is done at this fixed width and masked down to the real width.
    localparam int unsigned PTR_ARG_W = 32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [PTR_ARG_W-1:0] ptr_count(input logic [PTR_ARG_W-1:0] wr,
                                                       input logic [PTR_ARG_W-1:0] rd,
                                                       input int unsigned          ptr_w);
        logic [PTR_ARG_W-1:0] mask;
        mask = {PTR_ARG_W{1'b1}} >> (PTR_ARG_W - ptr_w);
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/bram_fifo_if.sv
// Handshake/status bundle of bram_fifo_fwft; peak exists only with BRAM_FIFO_WATERMARK_EN.
interface bram_fifo_if
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 1024
) ();
    localparam int unsigned CNT_W = ptr_width(DEPTH);

    logic             clear;
    logic             w_valid;
    logic [DATAW-1:0] w_data;
    logic             w_ready;
    logic             r_valid;
    logic [DATAW-1:0] r_data;
    logic             r_ready;
    logic [CNT_W-1:0] count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
`ifdef BRAM_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] peak;
`endif

    modport master (
        output clear, w_valid, w_data, r_ready,
        input  w_ready, r_valid, r_data, count, almost_full, almost_empty, overflow, underflow
`ifdef BRAM_FIFO_WATERMARK_EN
        , input peak
`endif
    );

    modport slave (
        input  clear, w_valid, w_data, r_ready,
        output w_ready, r_valid, r_data, count, almost_full, almost_empty, overflow, underflow
`ifdef BRAM_FIFO_WATERMARK_EN
        , output peak
`endif
    );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered (1-cycle) read.
module sdp_ram #(
    parameter int unsigned DATAW    = 32,
    parameter int unsigned ADDR_LEN = 10
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [ADDR_LEN-1:0] waddr_i,
    input  logic [DATAW-1:0]    wdata_i,
    input  logic                re_i,
    input  logic [ADDR_LEN-1:0] raddr_i,
    output logic [DATAW-1:0]    rdata_o
);
    localparam int unsigned WORDS = 1 << ADDR_LEN;

    logic [DATAW-1:0] mem_q [WORDS];

    // Read data holds its value while re_i is low; the FIFO relies on that to park a prefetched word.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/bram_fifo_fwft.sv
// Block-RAM FIFO with first-word-fall-through output, thresholds, flush and sticky error flags.
// Optional BRAM_FIFO_WATERMARK_EN adds a registered peak-occupancy output.
module bram_fifo_fwft
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DATAW     = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input logic       clk,
    input logic       rst,
    bram_fifo_if.slave fifo
);
    localparam int unsigned ADDR_LEN = $clog2(DEPTH);
    localparam int unsigned PTR_W    = ptr_width(DEPTH);

    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AEMPTY_TH);

    out_state_t state_q, state_d;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     count_q, count_d;
    logic                 dv_q, dv_d;
    logic [DATAW-1:0]     r_data_q, r_data_d;
    logic                 af_q, af_d;
    logic                 ae_q, ae_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 w_ready;
    logic                 r_valid;
    logic                 w_hs;
    logic                 r_hs;
    logic                 load;
    logic                 issue;
    logic [PTR_ARG_W-1:0] ram_level;
    logic [DATAW-1:0]     ram_rdata;

    sdp_ram #(
        .DATAW    (DATAW),
        .ADDR_LEN (ADDR_LEN)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_hs),
        .waddr_i (wr_ptr_q[ADDR_LEN-1:0]),
        .wdata_i (fifo.w_data),
        .re_i    (issue),
        .raddr_i (rd_ptr_q[ADDR_LEN-1:0]),
        .rdata_o (ram_rdata)
    );

    // dv_q marks a word parked in the RAM read register; it moves to the output register on load,
    // and a new read may replace it only in the same cycle it is loaded.
    always_comb begin
        w_ready   = !rst && !fifo.clear && (count_q < DEPTH_C);
        w_hs      = fifo.w_valid && w_ready;
        r_hs      = r_valid && fifo.r_ready && !fifo.clear;
        ram_level = ptr_count(PTR_ARG_W'(wr_ptr_q), PTR_ARG_W'(rd_ptr_q), PTR_W);
        load      = dv_q && (!r_valid || r_hs);
        issue     = !rst && !fifo.clear && (ram_level != '0) && (!dv_q || load);

        wr_ptr_d  = w_hs  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = issue ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({w_hs, r_hs})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
        dv_d      = issue || (dv_q && !load);
        r_data_d  = load ? ram_rdata : r_data_q;

        if (fifo.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dv_d     = 1'b0;
        end

        af_d  = (count_d >= AF_C);
        ae_d  = (count_d <= AE_C);
        ovf_d = ovf_q || (fifo.w_valid && !w_ready && !fifo.clear);
        unf_d = unf_q || (fifo.r_ready && !r_valid && !fifo.clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dv_q     <= 1'b0;
            r_data_q <= '0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dv_q     <= dv_d;
            r_data_q <= r_data_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY_OUT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fifo.clear) begin
            state_d = EMPTY_OUT;
        end else begin
            unique case (state_q)
                EMPTY_OUT: if (load)          state_d = HOLD;
                HOLD:      if (r_hs && !load) state_d = EMPTY_OUT;
                default:                      state_d = EMPTY_OUT;
            endcase
        end
    end

    always_comb begin
        r_valid = (state_q == HOLD);
    end

`ifdef BRAM_FIFO_WATERMARK_EN
    logic [PTR_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = (count_d > peak_q) ? count_d : peak_q;
        if (fifo.clear) peak_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign fifo.peak = peak_q;
`endif

    assign fifo.w_ready      = w_ready;
    assign fifo.r_valid      = r_valid;
    assign fifo.r_data       = r_data_q;
    assign fifo.count        = count_q;
    assign fifo.almost_full  = af_q;
    assign fifo.almost_empty = ae_q;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = unf_q;

endmodule

// File: tb/tb_bram_fifo_fwft.sv
// Randomised bench for bram_fifo_fwft against a queue model; checks peak when BRAM_FIFO_WATERMARK_EN is set.
module tb_bram_fifo_fwft;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned AE    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_fifo_if #(.DATAW(DW), .DEPTH(DEPTH)) bus ();

    bram_fifo_fwft #(
        .DATAW     (DW),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    // Each word becomes visible at the head two edges after the edge that wrote it.
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   avail;
    } entry_t;

    entry_t      q[$];
    int unsigned edge_n      = 0;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          m_ovf       = 1'b0;
    bit          m_unf       = 1'b0;
    int unsigned m_peak      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].avail <= edge_n);
    endfunction

    task automatic step(input bit r, input bit c, input bit wv, input logic [DW-1:0] wd, input bit rr);
        bit exp_wr;
        bit full;
        bit vld;
        @(negedge clk);
        exp_wr = !rst && !bus.clear && (q.size() < DEPTH);
        vld    = m_valid();
        chk("w_ready", 32'(bus.w_ready), 32'(exp_wr));
        chk("r_valid", 32'(bus.r_valid), 32'(vld));
        if (vld) chk("r_data", bus.r_data, q[0].data);
        if (rst) chk("r_data_rst", bus.r_data, 32'h0);
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef BRAM_FIFO_WATERMARK_EN
        chk("peak", 32'(bus.peak), m_peak);
`endif
        rst         = r;
        bus.clear   = c;
        bus.w_valid = wv;
        bus.w_data  = wd;
        bus.r_ready = rr;

        full = (q.size() >= DEPTH);
        edge_n++;
        if (r) begin
            q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_peak = 0;
        end else if (c) begin
            q.delete();
            m_peak = 0;
        end else begin
            if (wv && full) m_ovf = 1'b1;
            if (rr && !vld) m_unf = 1'b1;
            if (rr && vld) void'(q.pop_front());
            if (wv && !full) q.push_back('{data: wd, avail: edge_n + 2});
            if (q.size() > m_peak) m_peak = q.size();
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        for (int unsigned i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        bus.clear   = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.r_ready = 1'b0;

        do_reset();

        // three words, then read them back
        step(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h33, 1'b0);
        idle(3);
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(2);

        // fill past full, then drain past empty
        do_reset();
        for (int unsigned i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
        for (int unsigned i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // streaming across pointer wrap with constant occupancy
        do_reset();
        for (int unsigned i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
        idle(2);
        for (int unsigned i = 0; i < 3 * DEPTH + 4; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
        idle(2);

        // clear while holding 7 words with write and read both requested
        do_reset();
        for (int unsigned i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b1, $urandom, 1'b1);
        idle(2);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // random traffic with shifting write/read bias
        for (int unsigned blk = 0; blk < 6; blk++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 30 : 60;
            rp = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 80 : 60;
            for (int unsigned i = 0; i < 500; i++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 99) < wp,
                     $urandom,
                     $urandom_range(0, 99) < rp);
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
